// File: rtl/button_event_capture_pkg.sv
// rtl/button_event_capture_pkg.sv - shared constants for the button event capture block
package button_event_capture_pkg;

    localparam int NUM_BUTTONS_DEF = 5;

    localparam int LVL_LSB   = 0;
    localparam int PRESS_LSB = 8;
    localparam int REL_LSB   = 16;
    localparam int CNT_LSB   = 24;

    localparam int WORD_W      = 32;
    localparam int PRESS_CNT_W = 8;

    // Debounce counter must hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int dbc_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/button_event_capture_if.sv
// rtl/button_event_capture_if.sv - raw buttons, clear strobe and status word bundle
interface button_event_capture_if
    import button_event_capture_pkg::*;
#(
    parameter int NUM_BUTTONS = NUM_BUTTONS_DEF
) ();

    logic [NUM_BUTTONS-1:0] bt;
    logic                   clr;
    logic [WORD_W-1:0]      button;
    logic                   irq;

    modport master (
        output bt,
        output clr,
        input  button,
        input  irq
    );

    modport slave (
        input  bt,
        input  clr,
        output button,
        output irq
    );

endinterface

// File: rtl/button_debounce_ch.sv
// rtl/button_debounce_ch.sv - one button channel: 2-flop synchronizer, debounce counter, stable level
module button_debounce_ch
    import button_event_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int             CW      = dbc_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic [CW-1:0] cnt;
    logic          accept;

    // Level flips on the cycle the mismatch has lasted DEBOUNCE_CYCLES samples.
    assign accept = (sync_q != level) && (cnt == CNT_MAX);
    assign rise   = accept & ~level;
    assign fall   = accept &  level;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            level     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
            if (sync_q == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/button_event_capture.sv
// rtl/button_event_capture.sv - debounced buttons with sticky press/release bits, press counter and irq
module button_event_capture
    import button_event_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    button_event_capture_if.slave bus
);

    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] rise;
    logic [NUM_BUTTONS-1:0] fall;
    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] rel_q;
    logic [PRESS_CNT_W-1:0] press_cnt;
    logic [PRESS_CNT_W-1:0] press_inc;
    logic [WORD_W-1:0]      word;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (bus.bt[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    always_comb begin
        press_inc = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            press_inc = press_inc + PRESS_CNT_W'(rise[i]);
        end
    end

    always_comb begin
        word = '0;
        word[LVL_LSB   +: NUM_BUTTONS] = level;
        word[PRESS_LSB +: NUM_BUTTONS] = press_q;
        word[REL_LSB   +: NUM_BUTTONS] = rel_q;
        word[CNT_LSB   +: PRESS_CNT_W] = press_cnt;
    end

    // A transition landing in the same cycle as clr wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_q    <= '0;
            rel_q      <= '0;
            press_cnt  <= '0;
            bus.button <= '0;
            bus.irq    <= 1'b0;
        end else begin
            press_q    <= (bus.clr ? '0 : press_q) | rise;
            rel_q      <= (bus.clr ? '0 : rel_q)   | fall;
            press_cnt  <= press_cnt + press_inc;
            bus.button <= word;
            bus.irq    <= |press_q;
        end
    end

endmodule

// File: tb/tb_button_event_capture.sv
// tb/tb_button_event_capture.sv - directed self-checking bench for button_event_capture
module tb_button_event_capture;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    button_event_capture_if #(.NUM_BUTTONS(5)) bus ();

    button_event_capture #(
        .DEBOUNCE_CYCLES(4),
        .NUM_BUTTONS    (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.bt  = '0;
        bus.clr = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic press_release(input logic [4:0] mask);
        bus.bt = mask;
        step(7);
        bus.bt = '0;
        step(7);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset state
        do_reset();
        check_eq("rst_button", bus.button, 32'h0);
        check_eq("rst_irq", {31'b0, bus.irq}, 32'h0);

        // Clean press on bt[0]: level at edge 6, word at edge 7
        bus.bt = 5'b00001;
        step(6);
        check_eq("p0_edge6", bus.button, 32'h0);
        step(1);
        check_eq("p0_edge7", bus.button, 32'h01000101);
        check_eq("p0_irq", {31'b0, bus.irq}, 32'h1);

        // Glitch of 3 cycles on bt[2] is rejected
        do_reset();
        bus.bt = 5'b00100;
        step(3);
        bus.bt = '0;
        for (int i = 0; i < 10; i++) begin
            check_eq("glitch_button", bus.button, 32'h0);
            check_eq("glitch_irq", {31'b0, bus.irq}, 32'h0);
            step(1);
        end

        // A 4-cycle pulse is exactly long enough to be accepted
        do_reset();
        bus.bt = 5'b00100;
        step(4);
        bus.bt = '0;
        step(3);
        check_eq("pulse4_press", bus.button, 32'h01000404);

        // Press and release bt[1], then clear sticky bits
        do_reset();
        bus.bt = 5'b00010;
        step(7);
        check_eq("b1_press", bus.button, 32'h01000202);
        bus.bt = '0;
        step(7);
        check_eq("b1_release", bus.button, 32'h01020200);
        check_eq("b1_irq", {31'b0, bus.irq}, 32'h1);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        step(1);
        check_eq("b1_clr", bus.button, 32'h01000000);
        check_eq("b1_clr_irq", {31'b0, bus.irq}, 32'h0);

        // Simultaneous presses on bt[3]/bt[4], then clr coincident with bt[0] accept
        do_reset();
        bus.bt = 5'b11000;
        step(7);
        check_eq("dual_press", bus.button, 32'h02001818);
        bus.bt = 5'b11001;
        step(5);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        step(1);
        check_eq("clr_vs_press", bus.button, 32'h03000119);
        check_eq("clr_vs_press_irq", {31'b0, bus.irq}, 32'h1);

        // Counter wrap: 255 presses, then 256 more on bt[0]
        do_reset();
        for (int r = 0; r < 51; r++) press_release(5'b11111);
        check_eq("cnt_255", {24'h0, bus.button[31:24]}, 32'hff);
        press_release(5'b00001);
        check_eq("cnt_wrap0", {24'h0, bus.button[31:24]}, 32'h00);
        for (int r = 0; r < 255; r++) press_release(5'b00001);
        check_eq("cnt_end", {24'h0, bus.button[31:24]}, 32'hff);

        // Reset mid-debounce with bt[0] held
        do_reset();
        bus.bt = 5'b00001;
        step(4);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            check_eq("midrst_button", bus.button, 32'h0);
            check_eq("midrst_irq", {31'b0, bus.irq}, 32'h0);
        end
        reset = 1'b0;
        step(6);
        check_eq("midrst_edge6", bus.button, 32'h0);
        step(1);
        check_eq("midrst_edge7", bus.button, 32'h01000101);
        check_eq("midrst_irq_set", {31'b0, bus.irq}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
